shooter_game_core: RTL and testbench

- Parametrised successor to the shooting top-level game logic.
- Shooter moves along row 0 and fires bullets upward; catcher moves along row ROWS-1; a bullet arriving on the catcher's column scores for the shooter.
- Runs on one clock. Movement, bullet and scan rates come from single-cycle tick strobes, not divided clocks.
- Adds multiple bullets in flight, generic matrix size, and a PLAY/OVER game state machine. Drives the LED matrix scan and a 7-segment score digit.

---
 rtl/shooter_game_core.sv | 276 +++++++++++++++++++++++++++
 tb/tb_shooter_game_core.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/shooter_game_core.sv
// shooter_game_core
//   Two-player LED matrix game. A shooter on row 0 fires bullets upward and a
//   catcher on row ROWS-1 tries to be under them. Each bullet that arrives on
//   the catcher's column scores one point. The game stops at SCORE_MAX, and an
//   att edge then restarts it. All rates come from one-cycle tick strobes, so
//   the whole block runs on one clock.
//
// Optional build macro:
//   MISS_PENALTY_EN - each missed bullet subtracts one point, saturating at 0.
//                     Hits and misses in the same tick are net-summed and then
//                     clamped to 0..SCORE_MAX. Without it, a miss only frees
//                     its slot.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-low
//   tick_move    strobe: sample the movement buttons
//   tick_bullet  strobe: advance all bullets one row
//   tick_scan    strobe: step the matrix scan row
//   right0/left0 shooter buttons (level, active-high)
//   right1/left1 catcher buttons (level, active-high)
//   att          fire / restart button (level, rising edge acts)
//   row_out      one-hot scan row select, active-high
//   col_out      pixels of the selected row, active-low
//   seg          score digit {g,f,e,d,c,b,a}, active-low
//   game_over    high while the game is in OVER
module shooter_game_core #(
  parameter int COLS        = 8,
  parameter int ROWS        = 8,
  parameter int MAX_BULLETS = 4,
  parameter int SCORE_MAX   = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick_move,
  input  logic            tick_bullet,
  input  logic            tick_scan,
  input  logic            right0,
  input  logic            left0,
  input  logic            right1,
  input  logic            left1,
  input  logic            att,
  output logic [ROWS-1:0] row_out,
  output logic [COLS-1:0] col_out,
  output logic [6:0]      seg,
  output logic            game_over
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int IW = (MAX_BULLETS > 1) ? $clog2(MAX_BULLETS) : 1;
  localparam logic [XW-1:0] X_CENTRE  = XW'(COLS / 2);
  localparam logic [XW-1:0] X_LAST    = XW'(COLS - 1);
  localparam logic [XW-1:0] X_ONE     = {{(XW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] Y_ONE     = {{(YW-1){1'b0}}, 1'b1};
  localparam logic [YW-1:0] Y_PRE     = YW'(ROWS - 2);
  localparam logic [YW-1:0] Y_LAST    = YW'(ROWS - 1);
  localparam logic [3:0]    SCORE_TOP = 4'(SCORE_MAX);

  typedef enum logic {PLAY = 1'b0, OVER = 1'b1} state_t;

  state_t                 state_r, state_nx_s;
  logic [XW-1:0]          shooter_x_r, shooter_x_nx_s;
  logic [XW-1:0]          catcher_x_r, catcher_x_nx_s;
  logic [MAX_BULLETS-1:0] b_valid_r, b_valid_nx_s;
  logic [YW-1:0]          b_row_r [MAX_BULLETS];
  logic [YW-1:0]          b_row_nx_s [MAX_BULLETS];
  logic [XW-1:0]          b_col_r [MAX_BULLETS];
  logic [XW-1:0]          b_col_nx_s [MAX_BULLETS];
  logic [3:0]             score_r, score_nx_s;
  logic                   att_q_r;
  logic                   att_edge_s;
  logic [YW-1:0]          scan_r;
  logic                   free_found_s;
  logic [IW-1:0]          free_idx_s;
  logic [3:0]             hits_s;
`ifdef MISS_PENALTY_EN
  logic [3:0]             misses_s;
`endif
  int                     net_s;
  logic [ROWS-1:0]        row_s;
  logic [COLS-1:0]        col_lit_s;

  // Saturating one-step move; both or neither button pressed holds position.
  function automatic logic [XW-1:0] step_x(input logic [XW-1:0] x,
                                           input logic r, input logic l);
    logic [XW-1:0] res;
    if (r && !l && x != X_LAST)           res = x + X_ONE;
    else if (l && !r && x != {XW{1'b0}}) res = x - X_ONE;
    else                                  res = x;
    return res;
  endfunction

  // Score 0..9 to active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  assign att_edge_s = att & ~att_q_r;

  // Lowest free slot, judged on pre-cycle valid bits so a slot freed this
  // cycle only becomes reusable on the next one.
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = 0; i < MAX_BULLETS; i++) begin
      if (!b_valid_r[i] && !free_found_s) begin
        free_found_s = 1'b1;
        free_idx_s   = IW'(i);
      end else begin
      end
    end
  end

  // Game next-state: movement, bullet advance/resolve, spawn, score and FSM.
  always_comb begin
    state_nx_s     = state_r;
    shooter_x_nx_s = shooter_x_r;
    catcher_x_nx_s = catcher_x_r;
    b_valid_nx_s   = b_valid_r;
    b_row_nx_s     = b_row_r;
    b_col_nx_s     = b_col_r;
    score_nx_s     = score_r;
    hits_s         = 4'd0;
`ifdef MISS_PENALTY_EN
    misses_s       = 4'd0;
`endif
    net_s          = 32'sd0;
    case (state_r)
      PLAY: begin
        if (tick_move) begin
          shooter_x_nx_s = step_x(shooter_x_r, right0, left0);
          catcher_x_nx_s = step_x(catcher_x_r, right1, left1);
        end else begin
        end
        // Resolution compares against the pre-move catcher position.
        if (tick_bullet) begin
          for (int i = 0; i < MAX_BULLETS; i++) begin
            if (b_valid_r[i]) begin
              if (b_row_r[i] == Y_PRE) begin
                b_valid_nx_s[i] = 1'b0;
                if (b_col_r[i] == catcher_x_r) begin
                  hits_s = hits_s + 4'd1;
                end else begin
`ifdef MISS_PENALTY_EN
                  misses_s = misses_s + 4'd1;
`endif
                end
              end else begin
                b_row_nx_s[i] = b_row_r[i] + Y_ONE;
              end
            end else begin
            end
          end
        end else begin
        end
        // The chosen slot was invalid before this cycle, so the advance loop
        // never touches it and a fresh bullet stays on row 1.
        if (att_edge_s && free_found_s) begin
          b_valid_nx_s[free_idx_s] = 1'b1;
          b_row_nx_s[free_idx_s]   = Y_ONE;
          b_col_nx_s[free_idx_s]   = shooter_x_r;
        end else begin
        end
`ifdef MISS_PENALTY_EN
        net_s = int'(score_r) + int'(hits_s) - int'(misses_s);
`else
        net_s = int'(score_r) + int'(hits_s);
`endif
        if (net_s >= SCORE_MAX) begin
          score_nx_s = SCORE_TOP;
          state_nx_s = OVER;
        end else if (net_s <= 0) begin
          score_nx_s = 4'd0;
        end else begin
          score_nx_s = 4'(net_s);
        end
      end
      OVER: begin
        // Restart edge only resets the game; it never fires.
        if (att_edge_s) begin
          state_nx_s     = PLAY;
          shooter_x_nx_s = X_CENTRE;
          catcher_x_nx_s = X_CENTRE;
          b_valid_nx_s   = '0;
          score_nx_s     = 4'd0;
        end else begin
        end
      end
      default: begin
        state_nx_s = PLAY;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_r <= PLAY;
    else      state_r <= state_nx_s;
  end

  // Game datapath registers and att edge history.
  always_ff @(posedge clk) begin
    if (!rst) begin
      shooter_x_r <= X_CENTRE;
      catcher_x_r <= X_CENTRE;
      b_valid_r   <= '0;
      b_row_r     <= '{default: '0};
      b_col_r     <= '{default: '0};
      score_r     <= 4'd0;
      att_q_r     <= 1'b0;
    end else begin
      shooter_x_r <= shooter_x_nx_s;
      catcher_x_r <= catcher_x_nx_s;
      b_valid_r   <= b_valid_nx_s;
      b_row_r     <= b_row_nx_s;
      b_col_r     <= b_col_nx_s;
      score_r     <= score_nx_s;
      att_q_r     <= att;
    end
  end

  // Pixel set for the current scan row.
  always_comb begin
    row_s     = {{(ROWS-1){1'b0}}, 1'b1} << scan_r;
    col_lit_s = '0;
    if (state_r == OVER && (scan_r == {YW{1'b0}} || scan_r == Y_LAST)) begin
      col_lit_s = '1;
    end else begin
      if (scan_r == {YW{1'b0}}) col_lit_s[shooter_x_r] = 1'b1;
      else begin
      end
      if (scan_r == Y_LAST) col_lit_s[catcher_x_r] = 1'b1;
      else begin
      end
      for (int i = 0; i < MAX_BULLETS; i++) begin
        if (b_valid_r[i] && b_row_r[i] == scan_r) col_lit_s[b_col_r[i]] = 1'b1;
        else begin
        end
      end
    end
  end

  // Scan counter and registered display outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_r    <= '0;
      row_out   <= {{(ROWS-1){1'b0}}, 1'b1};
      col_out   <= '1;
      seg       <= 7'b1000000;
      game_over <= 1'b0;
    end else begin
      if (tick_scan) scan_r <= (scan_r == Y_LAST) ? {YW{1'b0}} : scan_r + Y_ONE;
      else           scan_r <= scan_r;
      row_out   <= row_s;
      col_out   <= ~col_lit_s;
      seg       <= seg_decode(score_r);
      game_over <= (state_r == OVER);
    end
  end

endmodule

// File: tb/tb_shooter_game_core.sv
// Bench for shooter_game_core (8x8, 4 bullet slots, game ends at 9).
// Stimulus pushes hand-computed display frames into a queue; the monitor
// pops one per falling edge and compares it with the DUT outputs.
module tb_shooter_game_core;

  logic       clk = 1'b0;
  logic       rst, tick_move, tick_bullet, tick_scan;
  logic       right0, left0, right1, left1, att;
  logic [7:0] row_out, col_out;
  logic [6:0] seg;
  logic       game_over;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S9 = 7'b0010000;

  typedef struct {
    string      name;
    logic [7:0] row;
    logic [7:0] col;
    logic [6:0] seg;
    logic       go;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   tests = 0;
  int   fails = 0;
  bit   done  = 1'b0;
  int   sr    = 0;

  shooter_game_core #(.COLS(8), .ROWS(8), .MAX_BULLETS(4), .SCORE_MAX(9)) dut (
    .clk(clk), .rst(rst), .tick_move(tick_move), .tick_bullet(tick_bullet),
    .tick_scan(tick_scan), .right0(right0), .left0(left0), .right1(right1),
    .left1(left1), .att(att), .row_out(row_out), .col_out(col_out),
    .seg(seg), .game_over(game_over)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic logic [7:0] lit(input int c);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << c);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [7:0] r, input logic [7:0] c,
                     input logic [6:0] s, input logic g);
    exp_t e;
    cyc(); cyc();
    e.name = n; e.row = r; e.col = c; e.seg = s; e.go = g;
    q.push_back(e);
    cyc();
  endtask

  task automatic moves(input int n);
    for (int i = 0; i < n; i++) begin
      tick_move = 1'b1; cyc(); tick_move = 1'b0; cyc();
    end
  endtask

  task automatic bullets(input int n);
    for (int i = 0; i < n; i++) begin
      tick_bullet = 1'b1; cyc(); tick_bullet = 1'b0; cyc();
    end
  endtask

  task automatic fire();
    att = 1'b1; cyc(); att = 1'b0; cyc();
  endtask

  task automatic scan_to(input int r);
    for (int k = 0; k < 8 && sr != r; k++) begin
      tick_scan = 1'b1; cyc(); tick_scan = 1'b0;
      sr = (sr + 1) % 8;
    end
  endtask

  // Monitor: one expected frame per falling edge, then the summary.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      cur = q.pop_front();
      tests++;
      if (row_out !== cur.row || col_out !== cur.col || seg !== cur.seg ||
          game_over !== cur.go) begin
        fails++;
        $display("FAIL %s: got row=%h col=%h seg=%b go=%b, expected row=%h col=%h seg=%b go=%b",
                 cur.name, row_out, col_out, seg, game_over,
                 cur.row, cur.col, cur.seg, cur.go);
      end
    end else if (done) begin
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    rst = 1'b0; tick_move = 1'b0; tick_bullet = 1'b0; tick_scan = 1'b0;
    right0 = 1'b0; left0 = 1'b0; right1 = 1'b0; left1 = 1'b0; att = 1'b0;
    cyc(); cyc();
    tests++;
    if (row_out !== 8'h01) begin
      fails++;
      $display("FAIL reset_row_out: got %h", row_out);
    end
    tests++;
    if (col_out !== 8'hFF) begin
      fails++;
      $display("FAIL reset_col_out: got %h", col_out);
    end
    tests++;
    if (seg !== S0) begin
      fails++;
      $display("FAIL reset_seg: got %b", seg);
    end
    tests++;
    if (game_over !== 1'b0) begin
      fails++;
      $display("FAIL reset_game_over: got %b", game_over);
    end
    chk("reset_outputs", 8'h01, 8'hFF, S0, 1'b0);
    rst = 1'b1;
    chk("shooter_centre", 8'h01, lit(4), S0, 1'b0);
    scan_to(7);
    chk("catcher_centre", 8'h80, lit(4), S0, 1'b0);

    // Movement saturation and the both-buttons hold.
    right0 = 1'b1; moves(6); right0 = 1'b0;
    scan_to(0);
    chk("shooter_sat_right", 8'h01, lit(7), S0, 1'b0);
    right1 = 1'b1; left1 = 1'b1; moves(3); right1 = 1'b0; left1 = 1'b0;
    scan_to(7);
    chk("catcher_both_hold", 8'h80, lit(4), S0, 1'b0);
    left0 = 1'b1; moves(9); left0 = 1'b0;
    scan_to(0);
    chk("shooter_sat_left", 8'h01, lit(0), S0, 1'b0);
    right0 = 1'b1; moves(4); right0 = 1'b0;

    // Five edges at columns 4,5,6,7,3: only the first four take a slot.
    fire();
    right0 = 1'b1; moves(1); right0 = 1'b0; fire();
    right0 = 1'b1; moves(1); right0 = 1'b0; fire();
    right0 = 1'b1; moves(1); right0 = 1'b0; fire();
    left0 = 1'b1; moves(4); left0 = 1'b0; fire();
    scan_to(1);
    chk("four_slots_only", 8'h02, 8'h0F, S0, 1'b0);
    scan_to(0);
    chk("shooter_at_3", 8'h01, lit(3), S0, 1'b0);

    // Reset mid-game discards bullets and recentres.
    rst = 1'b0; cyc(); rst = 1'b1; sr = 0;
    chk("midgame_reset_centre", 8'h01, lit(4), S0, 1'b0);
    scan_to(1);
    chk("midgame_reset_no_bullets", 8'h02, 8'hFF, S0, 1'b0);

    // Single hit: row 1 at spawn, six advances to resolve.
    fire();
    chk("spawn_row1", 8'h02, lit(4), S0, 1'b0);
    bullets(1); scan_to(2);
    chk("advance_row2", 8'h04, lit(4), S0, 1'b0);
    bullets(5); scan_to(7);
    chk("hit_score1", 8'h80, lit(4), S1, 1'b0);
    scan_to(6);
    chk("hit_slot_freed", 8'h40, 8'hFF, S1, 1'b0);

    // Free and spawn in one cycle: A frees slot 0 while D goes to slot 3,
    // E then reuses slot 0 and F finds no slot.
    fire(); bullets(1); fire(); fire(); bullets(4);
    tick_bullet = 1'b1; att = 1'b1; cyc(); tick_bullet = 1'b0; att = 1'b0; cyc();
    fire(); fire();
    scan_to(1);
    chk("spawn_during_free", 8'h02, lit(4), S2, 1'b0);
    scan_to(6);
    chk("inflight_row6", 8'h40, lit(4), S2, 1'b0);
    bullets(1);
    chk("two_hits_one_tick", 8'h40, 8'hFF, S4, 1'b0);
    bullets(5); scan_to(1);
    chk("fifth_edge_ignored", 8'h02, 8'hFF, S6, 1'b0);

    // Three more hits end the game.
    fire(); fire(); fire();
    right0 = 1'b1; moves(2); right0 = 1'b0;
    bullets(6); scan_to(0);
    chk("game_over", 8'h01, 8'h00, S9, 1'b1);
    left0 = 1'b1; moves(2); left0 = 1'b0; bullets(3);
    scan_to(7);
    chk("over_frozen", 8'h80, 8'h00, S9, 1'b1);
    fire();
    scan_to(1);
    chk("restart_no_bullet", 8'h02, 8'hFF, S0, 1'b0);
    scan_to(0);
    chk("restart_recentred", 8'h01, lit(4), S0, 1'b0);

    // Misses after reaching score 2.
    fire(); fire(); bullets(6);
    scan_to(1);
    chk("score_two", 8'h02, 8'hFF, S2, 1'b0);
    right0 = 1'b1; moves(1); right0 = 1'b0;
    fire(); bullets(6);
`ifdef MISS_PENALTY_EN
    chk("miss_once", 8'h02, 8'hFF, S1, 1'b0);
`else
    chk("miss_once", 8'h02, 8'hFF, S2, 1'b0);
`endif
    fire(); bullets(6);
`ifdef MISS_PENALTY_EN
    chk("miss_to_zero", 8'h02, 8'hFF, S0, 1'b0);
`else
    chk("miss_to_zero", 8'h02, 8'hFF, S2, 1'b0);
`endif
    fire(); bullets(6);
`ifdef MISS_PENALTY_EN
    chk("miss_at_zero", 8'h02, 8'hFF, S0, 1'b0);
`else
    chk("miss_at_zero", 8'h02, 8'hFF, S2, 1'b0);
`endif

    done = 1'b1;
    repeat (20) cyc();
  end

endmodule
